// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler
//   Time-shares one iterative binary-to-BCD (shift-add-3) engine among
//   NUM_REQ display requesters. It arbitrates round-robin, converts one
//   operand per grant at one bit per cycle, stores each requester's last
//   result in its own register, and pulses a one-cycle ack on completion.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high reset
//   req      : level request per requester
//   bin_in   : operands, requester i uses [i*BIN_WIDTH +: BIN_WIDTH]
//   ack      : one-cycle completion pulse per requester
//   bcd_out  : registered results, requester i uses [i*4*BCD_DIGITS +: 4*BCD_DIGITS]
//   busy     : high while a conversion is in flight (SHIFT and DONE)
//   grant_id : requester being served, holds last value when idle
module bcd_convert_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIN_WIDTH  = 14,
  parameter int unsigned BCD_DIGITS = 4,
  parameter int unsigned SAT_VALUE  = 9999
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]    bin_in,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ*4*BCD_DIGITS-1:0] bcd_out,
  output logic                            busy,
  output logic [2:0]                      grant_id
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH-1:0] SAT = BIN_WIDTH'(SAT_VALUE);
  localparam logic [2:0] LAST_RESET = 3'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [BCD_W-1:0]     slot_q [NUM_REQ];
  logic                 slot_we;

  // ---------------------------------------------------------------------
  // Round-robin pick: first eligible requester after the last grant.
  // A requester whose ack is currently high is masked so it cannot be
  // recaptured in the same cycle it is being told it was served.
  // ---------------------------------------------------------------------
  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  logic [2:0]           pick;
  logic [BIN_WIDTH-1:0] operand;
  logic [BIN_WIDTH-1:0] operand_sat;

  assign eligible = req & ~ack_q;

  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  assign operand     = bin_in[pick*BIN_WIDTH +: BIN_WIDTH];
  assign operand_sat = (operand > SAT) ? SAT : operand;

  // ---------------------------------------------------------------------
  // Add-3 correction applied to every digit before each shift.
  // ---------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    slot_we = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          bin_d   = operand_sat;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        slot_we = 1'b1;
        last_d  = grant_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The ack pulse is registered so it appears together with the slot write.
  always_comb begin
    ack_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_q == S_DONE) && (grant_q == 3'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        slot_q[i] <= '0;
      end else if (slot_we && (grant_q == 3'(i))) begin
        slot_q[i] <= bcd_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bcd_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bcd_out[i*BCD_W +: BCD_W] = slot_q[i];
    end
  end

  assign ack      = ack_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule
